// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV64M multiply/divide unit that stalls the pipeline front and aborts on flush
module ex_muldiv_unit #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic            word_i,
  input  logic [XLEN-1:0] src1_i,
  input  logic [XLEN-1:0] src2_i,
  input  logic            flush_i,
  output logic            stall_req_o,
  output logic [XLEN-1:0] result_o,
  output logic            result_valid_o
);
  localparam int CW = $clog2(XLEN) + 1;
  localparam int HW = XLEN - 32;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_n;
  logic [2:0] op;
  logic word, neg1, neg2;
  logic [CW-1:0] cnt;
  logic [XLEN-1:0] b;
  logic [2*XLEN-1:0] mc, acc, acc_n, prod;
  logic is_div, sg1, sg2, s1, s2, dz, ovf, special;
  logic [XLEN-1:0] x1, x2, n1, n2, m1, m2, sx1, special_res;
  logic [XLEN-1:0] mul_res, quo, rem, dv, final_res;
  logic [XLEN:0] trial, diff;
  assign is_div = op_i[2];
  assign sg1 = is_div ? !op_i[0] : op_i[1:0] != 2'd3;
  assign sg2 = is_div ? !op_i[0] : op_i[1:0] <= 2'd1;
  assign x1 = word_i ? {{HW{1'b0}}, src1_i[31:0]} : src1_i;
  assign x2 = word_i ? {{HW{1'b0}}, src2_i[31:0]} : src2_i;
  assign s1 = sg1 & (word_i ? src1_i[31] : src1_i[XLEN-1]);
  assign s2 = sg2 & (word_i ? src2_i[31] : src2_i[XLEN-1]);
  assign n1 = s1 ? -x1 : x1;
  assign n2 = s2 ? -x2 : x2;
  assign m1 = word_i ? {{HW{1'b0}}, n1[31:0]} : n1;
  assign m2 = word_i ? {{HW{1'b0}}, n2[31:0]} : n2;
  assign sx1 = word_i ? {{HW{src1_i[31]}}, src1_i[31:0]} : src1_i;
  assign dz = x2 == '0;
  assign ovf = sg1 & (word_i ? (src1_i[31:0] == 32'h8000_0000 && src2_i[31:0] == '1)
                             : (src1_i == {1'b1, {(XLEN-1){1'b0}}} && src2_i == '1));
  assign special = is_div & (dz | ovf);
  assign special_res = op_i[1] ? (dz ? sx1 : '0) : (dz ? '1 : sx1);
  assign trial = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
  assign diff = trial - {1'b0, b};
  assign acc_n = op[2] ? {diff[XLEN] ? trial[XLEN-1:0] : diff[XLEN-1:0], acc[XLEN-2:0], !diff[XLEN]}
                       : acc + (b[0] ? mc : '0);
  assign prod = neg1 ^ neg2 ? -acc_n : acc_n;
  assign mul_res = (op[1:0] == 2'd0 || word) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  assign quo = neg1 ^ neg2 ? -acc_n[XLEN-1:0] : acc_n[XLEN-1:0];
  assign rem = neg1 ? -acc_n[2*XLEN-1:XLEN] : acc_n[2*XLEN-1:XLEN];
  assign dv = op[2] ? (op[1] ? rem : quo) : mul_res;
  assign final_res = word ? {{HW{dv[31]}}, dv[31:0]} : dv;
  assign stall_req_o = ((state == IDLE && start_i) || state == CALC) && !flush_i && !rst;
  assign result_valid_o = state == DONE;
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = state;
    if (flush_i) state_n = IDLE;
    else if (state == IDLE) state_n = start_i ? (special ? DONE : CALC) : IDLE;
    else if (state == CALC) state_n = cnt == CW'(1) ? DONE : CALC;
    else state_n = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      result_o <= '0;
      op <= '0;
      word <= 1'b0;
      neg1 <= 1'b0;
      neg2 <= 1'b0;
      b <= '0;
      mc <= '0;
      acc <= '0;
    end else if (flush_i) begin
      cnt <= '0;
    end else if (state == IDLE && start_i) begin
      op <= op_i;
      word <= word_i;
      neg1 <= s1;
      neg2 <= s2;
      mc <= {{XLEN{1'b0}}, m1};
      b <= m2;
      acc <= is_div ? {{XLEN{1'b0}}, word_i ? {m1[31:0], {HW{1'b0}}} : m1} : '0;
      cnt <= word_i ? CW'(32) : CW'(XLEN);
      if (special) result_o <= special_res;
    end else if (state == CALC) begin
      acc <= acc_n;
      mc <= mc << 1;
      b <= op[2] ? b : b >> 1;
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) result_o <= final_res;
    end
  end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: table-driven, random and corner-sequence checks of ex_muldiv_unit
module tb_ex_muldiv_unit;
  logic clk = 1'b0, rst = 1'b1, start_i = 1'b0, word_i = 1'b0, flush_i = 1'b0;
  logic [2:0] op_i = '0;
  logic [63:0] src1_i = '0, src2_i = '0;
  logic stall_req_o, result_valid_o;
  logic [63:0] result_o;
  int checks = 0, errors = 0;
  logic [63:0] last_res = '0;
  typedef struct {logic [2:0] op; logic w; logic [63:0] a, b, exp; int st;} vec_t;
  vec_t vt[13];

  ex_muldiv_unit #(.XLEN(64)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .word_i(word_i),
    .src1_i(src1_i), .src2_i(src2_i), .flush_i(flush_i), .stall_req_o(stall_req_o),
    .result_o(result_o), .result_valid_o(result_valid_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] op, input logic w, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] p;
    logic [31:0] a32, b32, r32;
    logic [63:0] r;
    if (w) begin
      a32 = a[31:0];
      b32 = b[31:0];
      if (!op[2]) r32 = a32 * b32;
      else if (b32 == 0) r32 = op[1] ? a32 : 32'hFFFF_FFFF;
      else if (!op[0] && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = op[1] ? 32'd0 : a32;
      else if (!op[0]) r32 = op[1] ? $signed(a32) % $signed(b32) : $signed(a32) / $signed(b32);
      else r32 = op[1] ? a32 % b32 : a32 / b32;
      return {{32{r32[31]}}, r32};
    end
    case (op)
      3'd0: r = a * b;
      3'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; r = p[127:64]; end
      3'd2: begin p = {{64{a[63]}}, a} * {64'd0, b}; r = p[127:64]; end
      3'd3: begin p = {64'd0, a} * {64'd0, b}; r = p[127:64]; end
      default: begin
        if (b == 0) r = op[1] ? a : '1;
        else if (!op[0] && a == 64'h8000_0000_0000_0000 && b == '1) r = op[1] ? 64'd0 : a;
        else if (!op[0]) r = op[1] ? $signed(a) % $signed(b) : $signed(a) / $signed(b);
        else r = op[1] ? a % b : a / b;
      end
    endcase
    return r;
  endfunction

  function automatic int stalls(input logic [2:0] op, input logic w, input logic [63:0] a, input logic [63:0] b);
    logic dz, ov;
    dz = w ? b[31:0] == 0 : b == 0;
    ov = !op[0] && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                      : (a == 64'h8000_0000_0000_0000 && b == '1));
    return (op[2] && (dz || ov)) ? 1 : (w ? 33 : 65);
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 6))
      0: return 64'd0;
      1: return '1;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'hFFFF_FFFF_8000_0000;
      4: return 64'($urandom_range(0, 20));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic run_op(input logic [2:0] op, input logic w, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp, input int st, input string tag);
    int cyc = 0;
    @(negedge clk);
    start_i = 1'b1; op_i = op; word_i = w; src1_i = a; src2_i = b;
    #1;
    chk({tag, " idle_valid"}, 64'(result_valid_o), 64'd0);
    chk({tag, " held"}, result_o, last_res);
    while (stall_req_o && cyc < 200) begin
      cyc++;
      @(negedge clk);
      #1;
    end
    chk({tag, " stall_cycles"}, 64'(cyc), 64'(st));
    chk({tag, " done_valid"}, 64'(result_valid_o), 64'd1);
    chk({tag, " result"}, result_o, exp);
    last_res = exp;
  endtask

  initial begin
    vt[0]  = '{3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65};
    vt[1]  = '{3'd3, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65};
    vt[2]  = '{3'd1, 1'b0, '1, '1, 64'd0, 65};
    vt[3]  = '{3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65};
    vt[4]  = '{3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65};
    vt[5]  = '{3'd5, 1'b0, 64'd100, 64'd7, 64'd14, 65};
    vt[6]  = '{3'd7, 1'b0, 64'd100, 64'd7, 64'd2, 65};
    vt[7]  = '{3'd5, 1'b0, 64'd123, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
    vt[8]  = '{3'd6, 1'b0, 64'd5, 64'd0, 64'd5, 1};
    vt[9]  = '{3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1};
    vt[10] = '{3'd6, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 1};
    vt[11] = '{3'd4, 1'b1, 64'h0000_0000_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 33};
    vt[12] = '{3'd0, 1'b1, 64'h1_0000, 64'h1_0000, 64'd0, 33};
    start_i = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_stall", 64'(stall_req_o), 64'd0);
    rst = 1'b0;
    start_i = 1'b0;
    #1;
    chk("reset_result", result_o, 64'd0);
    chk("reset_valid", 64'(result_valid_o), 64'd0);
    chk("reset_idle_stall", 64'(stall_req_o), 64'd0);
    for (int i = 0; i < 13; i++)
      run_op(vt[i].op, vt[i].w, vt[i].a, vt[i].b, vt[i].exp, vt[i].st, $sformatf("vec%0d", i));
    for (int i = 0; i < 40; i++) begin
      logic [2:0] op;
      logic w;
      logic [63:0] a, b;
      op = 3'($urandom_range(0, 7));
      w = 1'($urandom_range(0, 1));
      a = pick();
      b = pick();
      run_op(op, w, a, b, model(op, w, a, b), stalls(op, w, a, b), $sformatf("rnd%0d op%0d w%0d", i, op, w));
    end
    @(negedge clk);
    start_i = 1'b1; op_i = 3'd4; word_i = 1'b0; src1_i = 64'd1000; src2_i = 64'd7;
    repeat (10) @(negedge clk);
    #1;
    chk("flush_pre_stall", 64'(stall_req_o), 64'd1);
    flush_i = 1'b1;
    #1;
    chk("flush_stall", 64'(stall_req_o), 64'd0);
    @(negedge clk);
    flush_i = 1'b0;
    start_i = 1'b0;
    begin
      int pulses = 0;
      repeat (70) begin
        @(negedge clk);
        #1;
        if (result_valid_o) pulses++;
      end
      chk("flush_no_valid", 64'(pulses), 64'd0);
    end
    chk("flush_stall_idle", 64'(stall_req_o), 64'd0);
    chk("flush_result_held", result_o, last_res);
    run_op(3'd0, 1'b0, 64'd3, 64'd4, 64'd12, 65, "after_flush");
    @(negedge clk);
    start_i = 1'b1; op_i = 3'd0; word_i = 1'b0; src1_i = 64'd5; src2_i = 64'd6;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_stall", 64'(stall_req_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    start_i = 1'b0;
    #1;
    chk("rst_mid_result", result_o, 64'd0);
    chk("rst_mid_valid", 64'(result_valid_o), 64'd0);
    chk("rst_mid_idle", 64'(stall_req_o), 64'd0);
    last_res = '0;
    run_op(3'd0, 1'b0, 64'd3, 64'd4, 64'd12, 65, "after_rst");
    @(negedge clk);
    start_i = 1'b0;
    #1;
    chk("final_valid_drop", 64'(result_valid_o), 64'd0);
    chk("final_result_held", result_o, 64'd12);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
